// File: rtl/check4_pkg.sv
// Shared constants for the check4 feature stage: default frame geometry,
// selector encodings and the 3x3 blur kernel weights.
package check4_pkg;

    localparam int DEF_WIDTH     = 800;
    localparam int DEF_HEIGHT    = 600;
    localparam int DEF_THRESHOLD = 16;

    localparam logic [4:0] SEL_RAW     = 5'd0;
    localparam logic [4:0] SEL_BLUR    = 5'd1;
    localparam logic [4:0] SEL_DIFF    = 5'd2;
    localparam logic [4:0] SEL_MASK    = 5'd3;
    localparam logic [4:0] SEL_OVERLAY = 5'd4;

    // Weights total 16, so the blur normalises with a 4-bit right shift.
    localparam logic [2:0] KERNEL_W [3][3] = '{'{3'd1, 3'd2, 3'd1},
                                               '{3'd2, 3'd4, 3'd2},
                                               '{3'd1, 3'd2, 3'd1}};

endpackage

// File: rtl/check4_line_buffer.sv
// WIDTH-deep 8-bit delay line: dout is the sample written WIDTH enables ago.
// Latency: WIDTH enabled cycles; output read combinationally from the slot about to be overwritten.
// No backpressure: shifts whenever en is high.
module check4_line_buffer
    import check4_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [7:0]    mem_q [WIDTH];
    logic [AW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (en) begin
            ptr_d = (ptr_q == AW'(WIDTH - 1)) ? '0 : ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Storage is deliberately not reset; stale rows only ever feed border or unprimed centers.
    always_ff @(posedge clock) begin
        if (en) begin
            mem_q[ptr_q] <= din;
        end
    end

    assign dout = mem_q[ptr_q];

endmodule

// File: rtl/check4_stage.sv
// 3x3 blur / difference / threshold stage with selectable view and 2x-decimated blur output.
// Latency: 2 cycles valid-to-validout; output image lags input by one row and one column.
// No backpressure: a pixel is consumed on every cycle valid is high.
module check4_stage
    import check4_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int HEIGHT    = DEF_HEIGHT,
    parameter int THRESHOLD = DEF_THRESHOLD
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] selector,
    input  logic [7:0] din,
    input  logic       valid,
    output logic [7:0] dout,
    output logic       validout,
    output logic [7:0] next_octave_dout,
    output logic       next_octave_valid
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    logic [CW-1:0] col_q, col_d, cen_col_q, cen_col_d;
    logic [RW-1:0] row_q, row_d, cen_row_q, cen_row_d;
    logic          primed_q, primed_d;
    logic          s1_vld_q, s1_vld_d, s1_prm_q, s1_prm_d;
    logic [7:0]    win_q [3][3];
    logic [7:0]    win_d [3][3];
    logic [7:0]    lb1_dat, lb2_dat;
    logic [7:0]    dout_q, dout_d, nov_dat_q, nov_dat_d;
    logic          vout_q, vout_d, nov_vld_q, nov_vld_d;

    check4_line_buffer #(.WIDTH(WIDTH)) u_lb1 (
        .clock(clock), .reset(reset), .en(valid), .din(din),     .dout(lb1_dat)
    );
    check4_line_buffer #(.WIDTH(WIDTH)) u_lb2 (
        .clock(clock), .reset(reset), .en(valid), .din(lb1_dat), .dout(lb2_dat)
    );

    // Input stage: raster counters, window shift, and coordinates of the new center.
    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        primed_d  = primed_q;
        win_d     = win_q;
        s1_vld_d  = valid;
        s1_prm_d  = s1_prm_q;
        cen_col_d = cen_col_q;
        cen_row_d = cen_row_q;
        if (valid) begin
            if (col_q == CW'(WIDTH - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(HEIGHT - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            // Pixel WIDTH+1 (row 1, col 0) completes the first usable window.
            if (row_q == RW'(1) && col_q == '0) begin
                primed_d = 1'b1;
            end
            s1_prm_d = primed_q;
            for (int r = 0; r < 3; r++) begin
                win_d[r][2] = win_q[r][1];
                win_d[r][1] = win_q[r][0];
            end
            win_d[0][0] = lb2_dat;
            win_d[1][0] = lb1_dat;
            win_d[2][0] = din;
            if (col_q == '0) begin
                cen_col_d = CW'(WIDTH - 1);
                cen_row_d = (row_q >= RW'(2)) ? row_q - RW'(2) : row_q + RW'(HEIGHT - 2);
            end else begin
                cen_col_d = col_q - CW'(1);
                cen_row_d = (row_q >= RW'(1)) ? row_q - RW'(1) : RW'(HEIGHT - 1);
            end
        end
    end

    logic [11:0] sum;
    logic [7:0]  cen_px, blur, diff, mask, view;
    logic        border, out_ok;

    always_comb begin
        sum = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                sum = sum + 12'(win_q[r][c]) * 12'(KERNEL_W[r][c]);
            end
        end
        cen_px = win_q[1][1];
        border = (cen_row_q == '0) || (cen_row_q == RW'(HEIGHT - 1)) ||
                 (cen_col_q == '0) || (cen_col_q == CW'(WIDTH - 1));
        blur   = border ? cen_px : 8'(sum >> 4);
        diff   = border ? 8'd0 : ((cen_px > blur) ? cen_px - blur : blur - cen_px);
        mask   = (32'(diff) > THRESHOLD) ? 8'hFF : 8'h00;
        case (selector)
            SEL_BLUR:    view = blur;
            SEL_DIFF:    view = diff;
            SEL_MASK:    view = mask;
            SEL_OVERLAY: view = (mask != 8'h00) ? 8'hFF : cen_px;
            default:     view = cen_px;
        endcase
        out_ok    = s1_vld_q && s1_prm_q;
        vout_d    = s1_vld_q;
        dout_d    = out_ok ? view : 8'd0;
        nov_vld_d = out_ok && !cen_row_q[0] && !cen_col_q[0];
        nov_dat_d = nov_vld_d ? blur : 8'd0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col_q     <= '0;
            row_q     <= '0;
            primed_q  <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_prm_q  <= 1'b0;
            cen_col_q <= '0;
            cen_row_q <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
            dout_q    <= '0;
            vout_q    <= 1'b0;
            nov_dat_q <= '0;
            nov_vld_q <= 1'b0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            primed_q  <= primed_d;
            s1_vld_q  <= s1_vld_d;
            s1_prm_q  <= s1_prm_d;
            cen_col_q <= cen_col_d;
            cen_row_q <= cen_row_d;
            win_q     <= win_d;
            dout_q    <= dout_d;
            vout_q    <= vout_d;
            nov_dat_q <= nov_dat_d;
            nov_vld_q <= nov_vld_d;
        end
    end

    assign dout              = dout_q;
    assign validout          = vout_q;
    assign next_octave_dout  = nov_dat_q;
    assign next_octave_valid = nov_vld_q;

endmodule

// File: tb/tb_check4_stage.sv
// Self-checking bench for check4_stage on a reduced 16x14 frame: scoreboard model plus impulse vector table.
module tb_check4_stage;

    localparam int W   = 16;
    localparam int H   = 14;
    localparam int TH  = 16;
    localparam int LAT = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] selector;
    logic [7:0] din;
    logic       valid;
    logic [7:0] dout;
    logic       validout;
    logic [7:0] nov_dat;
    logic       nov_vld;

    always #5 clock = ~clock;

    check4_stage #(.WIDTH(W), .HEIGHT(H), .THRESHOLD(TH)) dut (
        .clock(clock), .reset(reset), .selector(selector), .din(din), .valid(valid),
        .dout(dout), .validout(validout),
        .next_octave_dout(nov_dat), .next_octave_valid(nov_vld)
    );

    typedef struct {
        int         stamp;
        int         row;
        int         col;
        logic [7:0] dout;
        logic       nv;
        logic [7:0] nd;
    } exp_t;

    typedef struct {
        int         ir;
        int         ic;
        logic [4:0] sel;
        int         r;
        int         c;
        int         exp_val;
    } vec_t;

    exp_t sbq[$];
    int   strm[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   n_out = 0;
    int   n_nov = 0;
    int   cap [H][W];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference model: expected outputs for center stream index c (negative means not yet primed).
    function automatic void model(input int c, input logic [4:0] sel, output exp_t e);
        int row, col, cp, b, d, m, sum, v;
        e.stamp = 0;
        if (c < 0) begin
            e.row = -1; e.col = -1; e.dout = 8'd0; e.nv = 1'b0; e.nd = 8'd0;
            return;
        end
        col = c % W;
        row = (c / W) % H;
        cp  = strm[c];
        if (row == 0 || row == H - 1 || col == 0 || col == W - 1) begin
            b = cp;
            d = 0;
        end else begin
            sum = 4 * cp + 2 * (strm[c-1] + strm[c+1] + strm[c-W] + strm[c+W])
                + strm[c-W-1] + strm[c-W+1] + strm[c+W-1] + strm[c+W+1];
            b = sum / 16;
            d = (cp > b) ? cp - b : b - cp;
        end
        m = (d > TH) ? 255 : 0;
        case (sel)
            5'd1:    v = b;
            5'd2:    v = d;
            5'd3:    v = m;
            5'd4:    v = (m != 0) ? 255 : cp;
            default: v = cp;
        endcase
        e.row  = row;
        e.col  = col;
        e.dout = v[7:0];
        e.nv   = (row % 2 == 0) && (col % 2 == 0);
        e.nd   = e.nv ? b[7:0] : 8'd0;
    endfunction

    task automatic drive_px(input int d);
        exp_t e;
        strm.push_back(d);
        model(strm.size() - 1 - (W + 1), selector, e);
        e.stamp = cyc;
        sbq.push_back(e);
        valid = 1'b1;
        din   = d[7:0];
        @(posedge clock);
        #1 valid = 1'b0;
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        valid = 1'b0;
        sbq.delete();
        strm.delete();
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        n_out = 0;
        n_nov = 0;
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (validout) begin
                n_out++;
                if (nov_vld) n_nov++;
                check("pending_expectation", (sbq.size() != 0), 1);
                if (sbq.size() != 0) begin
                    mon_e = sbq.pop_front();
                    check("latency", cyc - mon_e.stamp, LAT);
                    check("dout", dout, mon_e.dout);
                    check("nov_valid", nov_vld, mon_e.nv);
                    if (mon_e.nv) check("nov_dout", nov_dat, mon_e.nd);
                    if (mon_e.row >= 0) cap[mon_e.row][mon_e.col] = dout;
                end
            end else begin
                check("nov_without_validout", nov_vld, 0);
            end
        end
    end

    vec_t tbl [];

    initial begin
        reset = 1'b1; valid = 1'b0; din = 8'd0; selector = 5'd0;

        tbl = new[22];
        tbl[0]  = '{10, 10, 5'd1, 10, 10, 63};
        tbl[1]  = '{10, 10, 5'd1, 10, 11, 31};
        tbl[2]  = '{10, 10, 5'd1, 11, 11, 15};
        tbl[3]  = '{10, 10, 5'd2, 10, 10, 192};
        tbl[4]  = '{10, 10, 5'd2, 10, 11, 31};
        tbl[5]  = '{10, 10, 5'd2, 11, 11, 15};
        tbl[6]  = '{10, 10, 5'd3, 10, 10, 255};
        tbl[7]  = '{10, 10, 5'd3,  9, 10, 255};
        tbl[8]  = '{10, 10, 5'd3, 11, 10, 255};
        tbl[9]  = '{10, 10, 5'd3, 10,  9, 255};
        tbl[10] = '{10, 10, 5'd3, 10, 11, 255};
        tbl[11] = '{10, 10, 5'd3,  9,  9, 0};
        tbl[12] = '{10, 10, 5'd3, 11, 11, 0};
        tbl[13] = '{10, 10, 5'd4, 10, 10, 255};
        tbl[14] = '{10, 10, 5'd4,  9, 10, 255};
        tbl[15] = '{10, 10, 5'd4, 11,  9, 0};
        tbl[16] = '{10, 10, 5'd7, 10, 10, 255};
        tbl[17] = '{10, 10, 5'd31, 10, 11, 0};
        tbl[18] = '{ 0,  5, 5'd2,  0,  5, 0};
        tbl[19] = '{ 0,  5, 5'd0,  0,  5, 255};
        tbl[20] = '{ 0,  5, 5'd1,  0,  5, 255};
        tbl[21] = '{ 0,  5, 5'd1,  1,  5, 31};

        @(posedge clock);
        #1;
        check("reset_dout", dout, 0);
        check("reset_validout", validout, 0);
        check("reset_nov_dout", nov_dat, 0);
        check("reset_nov_valid", nov_vld, 0);

        // Flat frame under blur, diff and mask views.
        for (int s = 1; s <= 3; s++) begin
            do_reset();
            selector = 5'(s);
            repeat (W * H) drive_px(100);
            idle(4);
            check("flat_output_count", n_out, W * H);
            check("flat_sb_empty", sbq.size(), 0);
            check($sformatf("flat_sel%0d_interior", s), cap[5][5], (s == 1) ? 100 : 0);
            check($sformatf("flat_sel%0d_border", s), cap[0][3], (s == 1) ? 100 : 0);
        end

        // Valid every other cycle.
        do_reset();
        selector = 5'd0;
        for (int i = 0; i < W * H + W + 1; i++) begin
            drive_px($urandom_range(0, 255));
            idle(1);
        end
        idle(4);
        check("gap_output_count", n_out, W * H + W + 1);
        check("gap_sb_empty", sbq.size(), 0);

        // Impulse and border vectors.
        foreach (tbl[i]) begin
            do_reset();
            selector = tbl[i].sel;
            for (int p = 0; p < W * H + W + 1; p++) begin
                drive_px((p / W == tbl[i].ir && p % W == tbl[i].ic) ? 255 : 0);
            end
            idle(4);
            check($sformatf("imp%0d_%0d_sel%0d_at_%0d_%0d", tbl[i].ir, tbl[i].ic, tbl[i].sel,
                            tbl[i].r, tbl[i].c), cap[tbl[i].r][tbl[i].c], tbl[i].exp_val);
        end

        // Two back-to-back frames for the next-octave stream.
        do_reset();
        selector = 5'd1;
        for (int p = 0; p < 2 * W * H; p++) drive_px($urandom_range(0, 255));
        for (int p = 0; p < W + 1; p++) drive_px(0);
        idle(4);
        check("nov_pulse_count", n_nov, 2 * (W / 2) * (H / 2));
        check("nov_sb_empty", sbq.size(), 0);

        // Mid-frame reset with valid held high, then a fresh frame.
        do_reset();
        selector = 5'd0;
        for (int p = 0; p < 100; p++) drive_px($urandom_range(1, 255));
        reset = 1'b1;
        valid = 1'b1;
        din   = 8'd77;
        #2;
        check("midreset_dout", dout, 0);
        check("midreset_validout", validout, 0);
        check("midreset_nov_dout", nov_dat, 0);
        check("midreset_nov_valid", nov_vld, 0);
        sbq.delete();
        strm.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        valid = 1'b0;
        n_out = 0;
        n_nov = 0;
        for (int p = 0; p < W * H + W + 1; p++) drive_px($urandom_range(1, 255));
        idle(4);
        check("fresh_output_count", n_out, W * H + W + 1);
        check("fresh_sb_empty", sbq.size(), 0);
        check("fresh_nov_count", n_nov, (W / 2) * (H / 2));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
